// File: rtl/wb_led_slave.sv
// Wishbone B4 pipelined slave for the LED/status bank: LED output register,
// set/clear aliases, masked blink generator, access counter, optional wait states.
module wb_led_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        i_reset,
   input  logic        i_wb_m2s_cyc,
   input  logic        i_wb_m2s_stb,
   input  logic        i_wb_m2s_we,
   input  logic [31:0] i_wb_m2s_addr,
   input  logic [31:0] i_wb_m2s_data,
   input  logic [3:0]  i_wb_m2s_sel,
   output logic        o_wb_s2m_ack,
   output logic        o_wb_s2m_stall,
   output logic [31:0] o_wb_s2m_data,
   output logic        o_wb_s2m_err,
   output logic [31:0] o_wb_s2m_err_addr,
   output logic [5:0]  o_leds
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        we_q;
   logic [31:0] addr_q, data_q;
   logic [3:0]  sel_q;
   logic        ack_q, err_q;
   logic [31:0] rdata_q, err_addr_q;
   logic [5:0]  led_q, mask_q, leds_q;
   logic [31:0] div_q, bcnt_q, acc_q;
   logic        phase_q;

   logic        stall, accept, wait_done, do_resp, hit, ok, bad, wr;
   logic        cur_we;
   logic [31:0] cur_addr, cur_data, lane_mask, wbits, div_merge, rdata;
   logic [3:0]  cur_sel;
   logic [2:0]  off;
   logic [5:0]  led_merge, mask_merge;

   assign stall     = (state_q == S_WAIT);
   assign accept    = i_wb_m2s_cyc & i_wb_m2s_stb & ~stall;
   assign wait_done = (state_q == S_WAIT) & i_wb_m2s_cyc & (wcnt_q == 4'd1);
   // Without wait states the response is produced on the accept edge itself
   assign do_resp   = (WAIT_STATES == 0) ? accept : wait_done;

   assign cur_we   = stall ? we_q   : i_wb_m2s_we;
   assign cur_addr = stall ? addr_q : i_wb_m2s_addr;
   assign cur_data = stall ? data_q : i_wb_m2s_data;
   assign cur_sel  = stall ? sel_q  : i_wb_m2s_sel;

   assign off = cur_addr[4:2];
   assign hit = (cur_addr[31:5] == BASE_ADDR[31:5]) && (off < 3'd6);
   assign ok  = do_resp & hit;
   assign bad = do_resp & ~hit;
   assign wr  = ok & cur_we;

   assign lane_mask  = {{8{cur_sel[3]}}, {8{cur_sel[2]}}, {8{cur_sel[1]}}, {8{cur_sel[0]}}};
   assign wbits      = cur_data & lane_mask;
   assign led_merge  = (led_q & ~lane_mask[5:0]) | wbits[5:0];
   assign mask_merge = (mask_q & ~lane_mask[5:0]) | wbits[5:0];
   assign div_merge  = (div_q & ~lane_mask) | wbits;

   always_comb begin
      rdata = 32'h0;
      case (off)
         3'd0, 3'd1, 3'd2: rdata = {26'h0, led_q};
         3'd3:             rdata = {26'h0, mask_q};
         3'd4:             rdata = div_q;
         3'd5:             rdata = acc_q;
         default:          rdata = 32'h0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_IDLE, S_RESP: begin
            state_d = S_IDLE;
            if (accept) begin
               if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  wcnt_d  = 4'(WAIT_STATES);
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_WAIT: begin
            // Master abandoning the cycle drops the pending access silently
            if (!i_wb_m2s_cyc)        state_d = S_IDLE;
            else if (wcnt_q == 4'd1)  state_d = S_RESP;
            else                      wcnt_d  = wcnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         wcnt_q     <= 4'h0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         data_q     <= 32'h0;
         sel_q      <= 4'h0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= 32'h0;
         err_addr_q <= 32'h0;
         led_q      <= 6'h0;
         mask_q     <= 6'h0;
         leds_q     <= 6'h0;
         div_q      <= 32'h0;
         bcnt_q     <= 32'h0;
         acc_q      <= 32'h0;
         phase_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         if (accept) begin
            we_q   <= i_wb_m2s_we;
            addr_q <= i_wb_m2s_addr;
            data_q <= i_wb_m2s_data;
            sel_q  <= i_wb_m2s_sel;
         end
         ack_q   <= ok;
         err_q   <= bad;
         rdata_q <= ok ? rdata : 32'h0;
         if (bad) err_addr_q <= cur_addr;
         if (ok)  acc_q <= acc_q + 32'd1;
         if (wr) begin
            case (off)
               3'd0:    led_q  <= led_merge;
               3'd1:    led_q  <= led_q | wbits[5:0];
               3'd2:    led_q  <= led_q & ~wbits[5:0];
               3'd3:    mask_q <= mask_merge;
               3'd4:    div_q  <= div_merge;
               default: ;
            endcase
         end
         if (wr && off == 3'd4) begin
            bcnt_q <= 32'h0;
         end else if (div_q != 32'h0) begin
            if (bcnt_q == div_q) begin
               bcnt_q  <= 32'h0;
               phase_q <= ~phase_q;
            end else begin
               bcnt_q <= bcnt_q + 32'd1;
            end
         end
         leds_q <= led_q ^ (mask_q & {6{phase_q}});
      end
   end

   assign o_wb_s2m_ack      = ack_q;
   assign o_wb_s2m_err      = err_q;
   assign o_wb_s2m_stall    = stall;
   assign o_wb_s2m_data     = rdata_q;
   assign o_wb_s2m_err_addr = err_addr_q;
   assign o_leds            = leds_q;
endmodule

// File: tb/tb_wb_led_slave.sv
// Directed bench: a zero-wait-state instance for the register map, blink and
// decode errors, and a two-wait-state instance for stall timing and abort.
module tb_wb_led_slave;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        c0_cyc, c0_stb, c0_we;
   logic [31:0] c0_addr, c0_wdat;
   logic [3:0]  c0_sel;
   logic        a0_ack, a0_stall, a0_err;
   logic [31:0] a0_dat, a0_eaddr;
   logic [5:0]  a0_leds;

   logic        c1_cyc, c1_stb, c1_we;
   logic [31:0] c1_addr, c1_wdat;
   logic [3:0]  c1_sel;
   logic        a1_ack, a1_stall, a1_err;
   logic [31:0] a1_dat, a1_eaddr;
   logic [5:0]  a1_leds;

   int nvec = 0;
   int nmis = 0;
   int exp_acks = 0;

   wb_led_slave #(.BASE_ADDR(32'h8000_0000), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .i_reset(rst),
      .i_wb_m2s_cyc(c0_cyc), .i_wb_m2s_stb(c0_stb), .i_wb_m2s_we(c0_we),
      .i_wb_m2s_addr(c0_addr), .i_wb_m2s_data(c0_wdat), .i_wb_m2s_sel(c0_sel),
      .o_wb_s2m_ack(a0_ack), .o_wb_s2m_stall(a0_stall), .o_wb_s2m_data(a0_dat),
      .o_wb_s2m_err(a0_err), .o_wb_s2m_err_addr(a0_eaddr), .o_leds(a0_leds));

   wb_led_slave #(.BASE_ADDR(32'h8000_0000), .WAIT_STATES(2)) u_dut1 (
      .clk(clk), .i_reset(rst),
      .i_wb_m2s_cyc(c1_cyc), .i_wb_m2s_stb(c1_stb), .i_wb_m2s_we(c1_we),
      .i_wb_m2s_addr(c1_addr), .i_wb_m2s_data(c1_wdat), .i_wb_m2s_sel(c1_sel),
      .o_wb_s2m_ack(a1_ack), .o_wb_s2m_stall(a1_stall), .o_wb_s2m_data(a1_dat),
      .o_wb_s2m_err(a1_err), .o_wb_s2m_err_addr(a1_eaddr), .o_leds(a1_leds));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Single request on the zero-wait instance; response sampled just after the accept edge
   task automatic xfer0(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic ack, output logic err,
                        output logic [31:0] rd);
      @(negedge clk);
      c0_cyc = 1'b1; c0_stb = 1'b1; c0_we = we; c0_addr = a; c0_wdat = d; c0_sel = s;
      @(posedge clk); #1;
      ack = a0_ack; err = a0_err; rd = a0_dat;
      c0_cyc = 1'b0; c0_stb = 1'b0; c0_we = 1'b0;
   endtask

   task automatic wr0(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
      logic ack, err;
      logic [31:0] rd;
      xfer0(1'b1, a, d, s, ack, err, rd);
      chk(tag, {err, ack}, 32'h1);
      exp_acks++;
   endtask

   task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic ack, err;
      logic [31:0] rd;
      xfer0(1'b0, a, 32'h0, 4'hF, ack, err, rd);
      chk({tag, "_ack"}, {err, ack}, 32'h1);
      chk(tag, rd, exp);
      exp_acks++;
   endtask

   initial begin
      logic ack, err;
      logic [31:0] rd;
      logic [5:0] prev;
      int gap, toggles, lat;

      rst = 1'b1;
      c0_cyc = 0; c0_stb = 0; c0_we = 0; c0_addr = 0; c0_wdat = 0; c0_sel = 0;
      c1_cyc = 0; c1_stb = 0; c1_we = 0; c1_addr = 0; c1_wdat = 0; c1_sel = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out0", {a0_leds, a0_ack, a0_err, a0_stall}, 32'h0);
      chk("rst_out1", {a1_leds, a1_ack, a1_err, a1_stall}, 32'h0);
      @(negedge clk); rst = 1'b0;

      rd0("rst_led", 32'h8000_0000, 32'h0);
      wr0("w_led", 32'h8000_0000, 32'h2A, 4'hF);
      @(posedge clk); #1;
      chk("leds_2a", {26'h0, a0_leds}, 32'h2A);
      rd0("rb_led", 32'h8000_0000, 32'h2A);

      // Pipelined burst: SET, read, CLR, read with an ack on every cycle
      @(negedge clk);
      c0_cyc = 1; c0_stb = 1; c0_we = 1; c0_addr = 32'h8000_0004; c0_wdat = 32'h05; c0_sel = 4'hF;
      @(posedge clk); #1;
      chk("b_set_ack", {a0_stall, a0_ack}, 32'h1);
      @(negedge clk); c0_we = 0; c0_addr = 32'h8000_0000;
      @(posedge clk); #1;
      chk("b_rd1_ack", {a0_stall, a0_ack}, 32'h1);
      chk("b_rd1", a0_dat, 32'h2F);
      @(negedge clk); c0_we = 1; c0_addr = 32'h8000_0008; c0_wdat = 32'h21;
      @(posedge clk); #1;
      chk("b_clr_ack", {a0_stall, a0_ack}, 32'h1);
      @(negedge clk); c0_we = 0; c0_addr = 32'h8000_0000;
      @(posedge clk); #1;
      chk("b_rd2_ack", {a0_stall, a0_ack}, 32'h1);
      chk("b_rd2", a0_dat, 32'h0E);
      c0_cyc = 0; c0_stb = 0;
      exp_acks += 4;
      @(posedge clk); #1;
      chk("idle_data", {a0_ack, a0_dat}, 33'h0);

      wr0("w_lane1", 32'h8000_0000, 32'h3F, 4'h2);
      rd0("rb_lane1", 32'h8000_0000, 32'h0E);
      wr0("w_div_b0", 32'h8000_0010, 32'hFFFF_FFFF, 4'h1);
      rd0("rb_div", 32'h8000_0010, 32'h0000_00FF);
      wr0("w_mask", 32'h8000_000C, 32'h03, 4'hF);
      rd0("rb_mask", 32'h8000_000C, 32'h03);
      wr0("w_div4", 32'h8000_0010, 32'h4, 4'hF);

      // Counter cleared on the DIV write edge; first visible toggle 6 edges later, then every 5
      prev = a0_leds;
      chk("blink_start", {26'h0, prev}, 32'h0E);
      gap = 0; toggles = 0;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         gap++;
         if (a0_leds !== prev) begin
            chk("blink_val", {26'h0, a0_leds}, {26'h0, prev ^ 6'h03});
            chk("blink_gap", gap, (toggles == 0) ? 6 : 5);
            toggles++;
            gap = 0;
            prev = a0_leds;
         end
      end
      chk("blink_toggles", toggles, 6);
      wr0("w_div0", 32'h8000_0010, 32'h0, 4'hF);
      wr0("w_mask0", 32'h8000_000C, 32'h0, 4'hF);

      rd0("cnt_a", 32'h8000_0014, exp_acks);
      xfer0(1'b0, 32'h8000_0018, 32'h0, 4'hF, ack, err, rd);
      chk("err_off6", {err, ack}, 32'h2);
      chk("err_addr6", a0_eaddr, 32'h8000_0018);
      rd0("cnt_b", 32'h8000_0014, exp_acks);
      xfer0(1'b1, 32'h9000_0000, 32'h3F, 4'hF, ack, err, rd);
      chk("err_base", {err, ack}, 32'h2);
      chk("err_addr_b", a0_eaddr, 32'h9000_0000);
      rd0("led_after_err", 32'h8000_0000, 32'h0E);
      wr0("w_cnt_ro", 32'h8000_0014, 32'h1234, 4'hF);
      rd0("cnt_c", 32'h8000_0014, exp_acks);

      @(negedge clk); c0_stb = 1; c0_cyc = 0; c0_addr = 32'h8000_0000;
      @(posedge clk); #1;
      chk("stb_no_cyc", {a0_ack, a0_err}, 32'h0);
      c0_stb = 0;

      // Two wait states: stall for two cycles, ack on the third
      @(negedge clk);
      c1_cyc = 1; c1_stb = 1; c1_we = 1; c1_addr = 32'h8000_0000; c1_wdat = 32'h15; c1_sel = 4'hF;
      @(posedge clk); #1;
      c1_stb = 0;
      chk("ws_p1", {a1_stall, a1_ack}, 32'h2);
      @(posedge clk); #1;
      chk("ws_p2", {a1_stall, a1_ack}, 32'h2);
      @(posedge clk); #1;
      chk("ws_p3", {a1_stall, a1_ack}, 32'h1);
      c1_cyc = 0;
      @(posedge clk); #1;
      chk("ws_p4", {a1_stall, a1_ack}, 32'h0);
      chk("ws_leds", {26'h0, a1_leds}, 32'h15);

      // Abort: cyc dropped during the first wait cycle
      @(negedge clk);
      c1_cyc = 1; c1_stb = 1; c1_we = 1; c1_addr = 32'h8000_0000; c1_wdat = 32'h2A;
      @(posedge clk); #1;
      chk("ab_stall", {a1_stall, a1_ack}, 32'h2);
      c1_cyc = 0; c1_stb = 0;
      @(posedge clk); #1;
      chk("ab_idle", {a1_stall, a1_ack, a1_err}, 32'h0);
      ack = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         ack = ack | a1_ack | a1_err;
      end
      chk("ab_noresp", ack, 32'h0);

      @(negedge clk);
      c1_cyc = 1; c1_stb = 1; c1_we = 0; c1_addr = 32'h8000_0000;
      @(posedge clk); #1;
      c1_stb = 0;
      lat = 1;
      while (!a1_ack && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("ws_rd_lat", lat, 3);
      chk("ws_rd_data", a1_dat, 32'h15);
      c1_cyc = 0;
      @(posedge clk); #1;
      chk("ab_leds", {26'h0, a1_leds}, 32'h15);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
